lcd_16207_sequencer: RTL

Timing-correct sequencer for the 16207 (HD44780-compatible) character LCD in 8-bit mode. It runs the power-on initialisation autonomously, then accepts one command or data byte at a time from a requester over a valid/ready handshake. For each byte it generates the LCD_RS/LCD_RW/LCD_E/LCD_data bus cycle with guaranteed setup, enable-width, hold and execution delays. It sits between the system-side LCD register interface and the LCD pins.

---
 rtl/lcd_16207_sequencer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_16207_sequencer.sv
// lcd_16207_sequencer: 16207/HD44780 8-bit bus sequencer with power-on init.
// Define LCD_BUSY_POLL_EN to replace execution waits with busy-flag polling.
module lcd_16207_sequencer #(
  parameter int T_AS       = 4,
  parameter int T_PW       = 15,
  parameter int T_HOLD     = 2,
  parameter int CMD_WAIT   = 2000,
  parameter int CLEAR_WAIT = 82000,
  parameter int INIT_WAIT  = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam logic [19:0] L_AS    = 20'(T_AS);
  localparam logic [19:0] L_PW    = 20'(T_PW);
  localparam logic [19:0] L_HOLD  = 20'(T_HOLD);
  localparam logic [19:0] L_CMD   = 20'(CMD_WAIT);
  localparam logic [19:0] L_CLEAR = 20'(CLEAR_WAIT);
  localparam logic [19:0] L_INIT  = 20'(INIT_WAIT);

  typedef enum logic [3:0] {
    S_RST_WAIT,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_WAIT,
`ifdef LCD_BUSY_POLL_EN
    S_P_SETUP,
    S_P_E_HIGH,
    S_P_HOLD,
`endif
    S_IDLE
  } state_t;

  state_t      r_state, n_state;
  logic [19:0] r_cnt, n_cnt;
  logic [2:0]  r_idx, n_idx;
  logic        r_init_done, n_init_done;
  logic        r_rs, n_rs;
  logic        r_rw, n_rw;
  logic        r_e, n_e;
  logic [7:0]  r_data, n_data;
`ifdef LCD_BUSY_POLL_EN
  logic        r_bf, n_bf;
  logic        w_poll;
`endif

  logic        w_last;
  logic        w_clear;
  logic [19:0] w_wait;
  logic [2:0]  w_idx_nx;
  logic        w_adv_idle;

  function automatic logic [7:0] f_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: f_rom = 8'h30;
      3'd3:             f_rom = 8'h38;
      3'd4:             f_rom = 8'h08;
      3'd5:             f_rom = 8'h01;
      3'd6:             f_rom = 8'h06;
      default:          f_rom = 8'h0C;
    endcase
  endfunction

  assign w_last     = (r_cnt <= 20'd1);
  assign w_clear    = !r_rs && ((r_data == 8'h01) || (r_data[7:1] == 7'h01));
  assign w_wait     = (!r_init_done && (r_idx < 3'd3)) ? L_INIT
                    : (w_clear ? L_CLEAR : L_CMD);
  assign w_idx_nx   = r_idx + 3'd1;
  assign w_adv_idle = r_init_done || (r_idx == 3'd7);
`ifdef LCD_BUSY_POLL_EN
  assign w_poll     = r_init_done || (r_idx >= 3'd3);
`endif

  assign req_ready = (r_state == S_IDLE) && r_init_done;
  assign init_done = r_init_done;
  assign LCD_E     = r_e;
  assign LCD_RS    = r_rs;
  assign LCD_RW    = r_rw;
`ifdef LCD_BUSY_POLL_EN
  assign LCD_data  = r_rw ? 8'bzzzz_zzzz : r_data;
`else
  assign LCD_data  = r_data;
`endif

  // State and bus registers; reset drops E and restarts the init sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RST_WAIT;
      r_cnt       <= L_INIT;
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_rw        <= 1'b0;
      r_e         <= 1'b0;
      r_data      <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
      r_bf        <= 1'b0;
`endif
    end else begin
      r_state     <= n_state;
      r_cnt       <= n_cnt;
      r_idx       <= n_idx;
      r_init_done <= n_init_done;
      r_rs        <= n_rs;
      r_rw        <= n_rw;
      r_e         <= n_e;
      r_data      <= n_data;
`ifdef LCD_BUSY_POLL_EN
      r_bf        <= n_bf;
`endif
    end
  end

  // Next-state: each timed state lasts r_cnt cycles; WAIT is loaded one
  // short so ready returns exactly T_AS+T_PW+T_HOLD+WAIT after accept.
  always_comb begin
    n_state     = r_state;
    n_cnt       = r_cnt;
    n_idx       = r_idx;
    n_init_done = r_init_done;
    n_rs        = r_rs;
    n_rw        = r_rw;
    n_e         = 1'b0;
    n_data      = r_data;
`ifdef LCD_BUSY_POLL_EN
    n_bf        = r_bf;
`endif
    unique case (r_state)
      S_RST_WAIT: begin
        if (w_last) begin
          n_state = S_SETUP;
          n_cnt   = L_AS;
          n_idx   = 3'd0;
          n_rs    = 1'b0;
          n_data  = f_rom(3'd0);
        end else begin
          n_cnt = r_cnt - 20'd1;
        end
      end
      S_SETUP: begin
        if (w_last) begin
          n_state = S_E_HIGH;
          n_cnt   = L_PW;
          n_e     = 1'b1;
        end else begin
          n_cnt = r_cnt - 20'd1;
        end
      end
      S_E_HIGH: begin
        if (w_last) begin
          n_state = S_HOLD;
          n_cnt   = L_HOLD;
        end else begin
          n_cnt = r_cnt - 20'd1;
          n_e   = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_last) begin
`ifdef LCD_BUSY_POLL_EN
          if (w_poll) begin
            n_state = S_P_SETUP;
            n_cnt   = L_AS;
            n_rs    = 1'b0;
            n_rw    = 1'b1;
          end else begin
            n_state = S_WAIT;
            n_cnt   = w_wait - 20'd1;
          end
`else
          n_state = S_WAIT;
          n_cnt   = w_wait - 20'd1;
`endif
        end else begin
          n_cnt = r_cnt - 20'd1;
        end
      end
      S_WAIT: begin
        if (w_last) begin
          if (w_adv_idle) begin
            n_state     = S_IDLE;
            n_init_done = 1'b1;
          end else begin
            n_state = S_SETUP;
            n_cnt   = L_AS;
            n_idx   = w_idx_nx;
            n_data  = f_rom(w_idx_nx);
          end
        end else begin
          n_cnt = r_cnt - 20'd1;
        end
      end
`ifdef LCD_BUSY_POLL_EN
      S_P_SETUP: begin
        if (w_last) begin
          n_state = S_P_E_HIGH;
          n_cnt   = L_PW;
          n_e     = 1'b1;
        end else begin
          n_cnt = r_cnt - 20'd1;
        end
      end
      S_P_E_HIGH: begin
        if (w_last) begin
          n_state = S_P_HOLD;
          n_cnt   = L_HOLD;
          n_bf    = LCD_data[7];
        end else begin
          n_cnt = r_cnt - 20'd1;
          n_e   = 1'b1;
        end
      end
      S_P_HOLD: begin
        if (!w_last) begin
          n_cnt = r_cnt - 20'd1;
        end else if (r_bf) begin
          n_state = S_P_SETUP;
          n_cnt   = L_AS;
        end else begin
          n_rw = 1'b0;
          if (w_adv_idle) begin
            n_state     = S_IDLE;
            n_init_done = 1'b1;
          end else begin
            n_state = S_SETUP;
            n_cnt   = L_AS;
            n_idx   = w_idx_nx;
            n_data  = f_rom(w_idx_nx);
          end
        end
      end
`endif
      S_IDLE: begin
        if (req_valid && r_init_done) begin
          n_state = S_SETUP;
          n_cnt   = L_AS;
          n_rs    = req_rs;
          n_data  = req_data;
        end
      end
      default: begin
        n_state = S_RST_WAIT;
        n_cnt   = L_INIT;
      end
    endcase
  end

endmodule
